// File: rtl/adder_multicycle.sv
// Multi-cycle ripple adder/subtractor, CHUNK bits per clock, registered carry between chunks.
// Define ADDER_MULTICYCLE_ACCUMULATE_EN to add the Acc port (opA taken from Sum).
module adder_multicycle #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Sub,
`ifdef ADDER_MULTICYCLE_ACCUMULATE_EN
  input  logic             Acc,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] a_src;
  logic [CW-1:0]    count;
  logic             cy;
  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK-1:0] s_ch;
  logic             c_out;
  logic             last;
  int               idx;

  always_comb begin
`ifdef ADDER_MULTICYCLE_ACCUMULATE_EN
    a_src = Acc ? Sum : A;
`else
    a_src = A;
`endif
  end

  always_comb begin
    idx  = int'(count) * CHUNK;
    a_ch = op_a[idx +: CHUNK];
    b_ch = op_b[idx +: CHUNK];
    {c_out, s_ch} = {1'b0, a_ch}
                  + {1'b0, b_ch}
                  + {{CHUNK{1'b0}}, cy};
    res = work;
    res[idx +: CHUNK] = s_ch;
    last = (count == LAST);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (Start) state_nxt = BUSY;
      BUSY:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      op_a     <= '0;
      op_b     <= '0;
      work     <= '0;
      count    <= '0;
      cy       <= 1'b0;
      Sum      <= '0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      if (state == IDLE && Start) begin
        op_a  <= a_src;
        op_b  <= Sub ? ~B : B;
        cy    <= Sub;
        count <= '0;
        work  <= '0;
      end else if (state == BUSY) begin
        work  <= res;
        cy    <= c_out;
        count <= count + CW'(1);
        if (last) begin
          Sum      <= res;
          Carry    <= c_out;
          // carry into MSB recovered from the MSB sum bit, so any CHUNK works
          Overflow <= op_a[WIDTH-1] ^ op_b[WIDTH-1]
                    ^ res[WIDTH-1] ^ c_out;
        end
      end
    end
  end

  assign Busy = (state == BUSY);
  assign Done = (state == DONE);

endmodule
